draw_port_arbiter: RTL
======================

// Module: draw_port_arbiter
// PURPOSE
//  Shares the single VGA adapter plot port between pixel-drawing requesters (map, link, enemies, HUD).
//  Grants are round-robin. A requester holding lock keeps its grant for a whole sprite burst.
//  Sits between the draw engines enabled by the game control FSM and the VGA adapter write port.
//  Output is registered and one pixel is emitted per cycle.
// PARAMETERS
//  N_REQ        4    number of requesters (2..8)
//  X_W          9    pixel x width
//  Y_W          8    pixel y width
//  COLOUR_W     9    pixel colour width
//  TRANS_KEY    0    colour treated as transparent (used only when ARB_TRANSPARENT_EN is defined)
// PORTS
//  clock        in   1                  system clock
//  reset        in   1                  synchronous, active-high
//  req_valid    in   N_REQ              requester i presents a pixel beat
//  req_lock     in   N_REQ              1 = more beats follow in this burst; 0 on the last beat
//  req_x        in   N_REQ*X_W          packed x; requester i at [i*X_W +: X_W]
//  req_y        in   N_REQ*Y_W          packed y
//  req_colour   in   N_REQ*COLOUR_W     packed colour
//  req_ready    out  N_REQ              beat accepted when valid & ready on the same edge
//  plot         out  1                  write strobe to the VGA adapter
//  plot_x       out  X_W                pixel x
//  plot_y       out  Y_W                pixel y
//  plot_colour  out  COLOUR_W           pixel colour
//  grant_id     out  $clog2(N_REQ)      current owner; valid while busy
//  busy         out  1                  a tenure is in progress
//  plot_count   out  16                 total beats accepted, wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0 on the next edge, FSM -> S_ARB, rr_ptr = N_REQ-1. Reset mid-burst drops the burst.
//  S_ARB: req_ready = 0.
//    - If any req_valid: the winner is the first valid requester at or after index rr_ptr+1 (mod N_REQ).
//      Latch owner into grant_id, set busy=1, go to S_OWN. Arbitration costs 1 cycle.
//    - Otherwise stay in S_ARB.
//  S_OWN: req_ready[owner] = 1 (registered-state decode only, with no combinational path from req_valid).
//    All other ready bits are 0.
//    - On an accepted beat, the beat is registered. Next cycle: plot=1 and plot_x/y/colour carry that beat.
//      Latency is accept edge + 1.
//    - An accepted beat with req_lock[owner]=0 ends the tenure: rr_ptr=owner, busy=0, go to S_ARB.
//    - If req_valid[owner]=0 while lock=1, hold the tenure and emit no plot (stall).
//    - If req_valid[owner]=0 and lock=0, release without a beat.
//  plot is high only in the cycle after an accepted beat; the plot_* data holds its last value otherwise.
//  plot_count increments on every accepted beat, including beats suppressed by transparency.
//  Fairness: a requester waits at most N_REQ-1 tenures.
//  Throughput: B beats cost B+1 cycles (plus stalls).
//  Changes to valid from non-owners during S_OWN are ignored. Those requesters must hold valid until ready.
// CONFIGURATION
//  ARB_TRANSPARENT_EN defined:
//    - A beat with colour == TRANS_KEY is accepted normally (ready, lock and count all apply).
//    - plot stays 0 for it, so the sprite background is skipped.
//  Not defined: every accepted beat is plotted and TRANS_KEY is ignored.
// STRUCTURE
//  Shared package zelda_draw_pkg holds:
//    - X_W, Y_W and COLOUR_W defaults
//    - the state encoding S_ARB=1'b0, S_OWN=1'b1
//    - the default TRANS_KEY.
//  Sub-module rr_pick: combinational round-robin picker.
//    - Inputs: valid[N_REQ] and ptr. Outputs: idx and any.
//    - Uses a double-width mask-and-priority scheme.
//  The top level holds the FSM, the owner/ptr registers, the output pipeline register and the counter.
// TESTING
//  1. Reset, then req0 single beat (x=5,y=7,c=0x1FF,lock=0):
//     ready0 high in cycle 2; plot=1 with 5/7/0x1FF in cycle 3; busy low after; plot_count=1.
//  2. All 4 requesters valid with single beats, held:
//     grants in order 0,1,2,3,0; no requester is granted twice before all others are served.
//  3. req2 burst of 16 beats (lock=1 on 15, lock=0 on last) while req1 is valid:
//     16 consecutive plots from req2 with no interleave, then req1 is granted.
//  4. Owner drops valid for 3 cycles mid-burst with lock=1:
//     no plot in those cycles, grant kept, burst completes with the correct beat count.
//  5. Assert reset during beat 5 of a burst:
//     next cycle plot=0, busy=0, ready=0, plot_count=0; a new request is granted starting from req0.
//  6. With ARB_TRANSPARENT_EN, 4 beats where beats 1 and 3 have colour=TRANS_KEY:
//     2 plots, plot_count=4. Without the macro: 4 plots.

Source files
------------

// File: rtl/zelda_draw_pkg.sv
// zelda_draw_pkg: shared pixel widths, arbiter state encoding and transparent colour default.
package zelda_draw_pkg;
  localparam int X_W_DEF = 9;
  localparam int Y_W_DEF = 8;
  localparam int COLOUR_W_DEF = 9;
  localparam int TRANS_KEY_DEF = 0;
  typedef enum logic {S_ARB = 1'b0, S_OWN = 1'b1} state_t;
endpackage

// File: rtl/draw_port_arbiter_if.sv
// draw_port_arbiter_if: requester beats in, VGA plot port and arbiter status out.
interface draw_port_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int COLOUR_W = 9
);
  localparam int GW = $clog2(N_REQ);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_lock;
  logic [N_REQ*X_W-1:0] req_x;
  logic [N_REQ*Y_W-1:0] req_y;
  logic [N_REQ*COLOUR_W-1:0] req_colour;
  logic [N_REQ-1:0] req_ready;
  logic plot;
  logic [X_W-1:0] plot_x;
  logic [Y_W-1:0] plot_y;
  logic [COLOUR_W-1:0] plot_colour;
  logic [GW-1:0] grant_id;
  logic busy;
  logic [15:0] plot_count;
  modport master (
    output req_valid, req_lock, req_x, req_y, req_colour,
    input req_ready, plot, plot_x, plot_y, plot_colour, grant_id, busy, plot_count
  );
  modport slave (
    input req_valid, req_lock, req_x, req_y, req_colour,
    output req_ready, plot, plot_x, plot_y, plot_colour, grant_id, busy, plot_count
  );
endinterface

// File: rtl/draw_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid index strictly after ptr (wrapping).
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    idx,
  output logic             any
);
  localparam int W2 = 2 * N_REQ;
  logic [W2-1:0] masked;
  int pos;
  // The upper copy of valid catches the wrap-around once bits up to ptr are masked off.
  always_comb begin
    masked = {valid, valid} & ~((W2'(2) << ptr) - W2'(1));
    pos = 0;
    for (int i = W2 - 1; i >= 0; i--) pos = masked[i] ? i : pos;
    idx = PW'(pos >= N_REQ ? pos - N_REQ : pos);
    any = |valid;
  end
endmodule

// File: rtl/draw_port_arbiter.sv
// draw_port_arbiter: round-robin owner of the VGA plot port with locked bursts; ARB_TRANSPARENT_EN skips TRANS_KEY pixels.
module draw_port_arbiter
  import zelda_draw_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter logic [COLOUR_W-1:0] TRANS_KEY = COLOUR_W'(TRANS_KEY_DEF)
) (
  input logic clock,
  input logic reset,
  draw_port_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_REQ);
`ifdef ARB_TRANSPARENT_EN
  localparam logic SKIP_KEY = 1'b1;
`else
  localparam logic SKIP_KEY = 1'b0;
`endif
  state_t state;
  logic [GW-1:0] rr_ptr, pick_idx;
  logic pick_any, own_valid, own_lock;
  logic [X_W-1:0] beat_x;
  logic [Y_W-1:0] beat_y;
  logic [COLOUR_W-1:0] beat_colour;
  rr_pick #(.N_REQ(N_REQ), .PW(GW)) u_pick (
    .valid(bus.req_valid),
    .ptr(rr_ptr),
    .idx(pick_idx),
    .any(pick_any)
  );
  always_comb begin
    own_valid = bus.req_valid[bus.grant_id];
    own_lock = bus.req_lock[bus.grant_id];
    beat_x = bus.req_x[int'(bus.grant_id)*X_W +: X_W];
    beat_y = bus.req_y[int'(bus.grant_id)*Y_W +: Y_W];
    beat_colour = bus.req_colour[int'(bus.grant_id)*COLOUR_W +: COLOUR_W];
  end
  // Ready depends only on registered state so requesters see no valid->ready loop.
  assign bus.req_ready = (state == S_OWN) ? (N_REQ'(1) << bus.grant_id) : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_ARB;
      rr_ptr <= GW'(N_REQ - 1);
      bus.grant_id <= '0;
      bus.busy <= 1'b0;
      bus.plot <= 1'b0;
      bus.plot_x <= '0;
      bus.plot_y <= '0;
      bus.plot_colour <= '0;
      bus.plot_count <= '0;
    end else begin
      bus.plot <= 1'b0;
      if (state == S_ARB) begin
        if (pick_any) begin
          bus.grant_id <= pick_idx;
          bus.busy <= 1'b1;
          state <= S_OWN;
        end
      end else begin
        if (own_valid) begin
          bus.plot <= !(SKIP_KEY && beat_colour == TRANS_KEY);
          bus.plot_x <= beat_x;
          bus.plot_y <= beat_y;
          bus.plot_colour <= beat_colour;
          bus.plot_count <= bus.plot_count + 16'd1;
        end
        // lock low ends the tenure whether or not a beat came with it
        if (!own_lock) begin
          rr_ptr <= bus.grant_id;
          bus.busy <= 1'b0;
          state <= S_ARB;
        end
      end
    end
  end
endmodule
